// File: rtl/dffre_bist_pkg.sv
// Shared types and constants for the dffre_inst built-in self-test engine.
package dffre_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic d;
        logic r;
        logic e;
    } vec_t;

    localparam int NUM_DIRECTED = 5;

    // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic vec_t directed_vec(input int idx);
        vec_t v;
        case (idx)
            0:       v = '{d: 1'b1, r: 1'b1, e: 1'b0};
            1:       v = '{d: 1'b1, r: 1'b0, e: 1'b0};
            2:       v = '{d: 1'b1, r: 1'b0, e: 1'b1};
            3:       v = '{d: 1'b0, r: 1'b0, e: 1'b1};
            default: v = '{d: 1'b1, r: 1'b0, e: 1'b1};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit Galois LFSR with seed load and advance enable; exposes only the
// current and next output bit used as random D stimulus.
module bist_lfsr32
    import dffre_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2345
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic out_bit,
    output logic nxt_bit
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_nxt;

    if (SEED == 32'd0) begin : g_seed_chk
        $error("bist_lfsr32: SEED must be nonzero");
    end

    assign lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    assign out_bit  = lfsr_q[0];
    assign nxt_bit  = lfsr_nxt[0];

    always_ff @(posedge clk) begin
        if (rst || load) begin
            lfsr_q <= SEED;
        end else if (en) begin
            lfsr_q <= lfsr_nxt;
        end
    end

endmodule

// File: rtl/dffre_bist.sv
// Self-test engine for dffre_inst: directed then LFSR-random stimulus, golden vs
// netlist Q compare. Optional first-fail capture: DFFRE_BIST_FIRSTFAIL_EN.
module dffre_bist
    import dffre_bist_pkg::*;
#(
    parameter int          NUM_RANDOM = 1000,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2345,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             i_Reset,
    input  logic             i_Start,
    output logic             o_D,
    output logic             o_DutReset,
    output logic             o_Enable,
    input  logic             i_Q_golden,
    input  logic             i_Q_netlist,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Pass,
    output logic [CNT_W-1:0] o_MismatchCnt,
    output logic [15:0]      o_FirstFailStep,
    output logic             o_FirstFailValid
);

    localparam int NUM_STEPS = NUM_DIRECTED + NUM_RANDOM;
    localparam int STEP_W    = (NUM_STEPS > 2) ? $clog2(NUM_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state, state_nxt;
    logic [STEP_W-1:0] step;
    logic [CNT_W-1:0]  cnt;
    vec_t              vec_q, vec_next;
    logic              start_ok, check_exit, last_step, mismatch, in_random;
    logic              lfsr_bit, lfsr_nxt_bit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign start_ok   = i_Start && (state == ST_IDLE || state == ST_DONE);
    assign check_exit = (state == ST_CHECK);
    assign last_step  = (step == LAST_STEP);
    assign mismatch   = (i_Q_golden != i_Q_netlist);
    assign in_random  = (int'(step) >= NUM_DIRECTED);

    bist_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (i_Reset),
        .load    (start_ok),
        .en      (check_exit && in_random),
        .out_bit (lfsr_bit),
        .nxt_bit (lfsr_nxt_bit)
    );

    always_ff @(posedge clk) begin
        if (i_Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_Busy    = 1'b0;
        o_Done    = 1'b0;
        case (state)
            ST_IDLE:  if (i_Start) state_nxt = ST_APPLY;
            ST_APPLY: begin state_nxt = ST_WAIT;  o_Busy = 1'b1; end
            ST_WAIT:  begin state_nxt = ST_CHECK; o_Busy = 1'b1; end
            ST_CHECK: begin
                state_nxt = last_step ? ST_DONE : ST_APPLY;
                o_Busy    = 1'b1;
            end
            ST_DONE:  begin
                o_Done = 1'b1;
                if (i_Start) state_nxt = ST_APPLY;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Random D comes from the LFSR value that will be current once this edge
    // has advanced it (only already-random steps advance it on exit).
    always_comb begin
        vec_next = '{d: (in_random ? lfsr_nxt_bit : lfsr_bit), r: 1'b0, e: 1'b1};
        if (int'(step) + 1 < NUM_DIRECTED) begin
            vec_next = directed_vec(int'(step) + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_Reset) begin
            step  <= '0;
            cnt   <= '0;
            vec_q <= '{d: 1'b0, r: 1'b1, e: 1'b0};
        end else if (start_ok) begin
            step  <= '0;
            cnt   <= '0;
            vec_q <= directed_vec(0);
        end else if (check_exit) begin
            if (mismatch) cnt <= sat_inc(cnt);
            if (!last_step) begin
                step  <= step + 1'b1;
                vec_q <= vec_next;
            end
        end
    end

    assign o_D           = vec_q.d;
    assign o_DutReset    = vec_q.r;
    assign o_Enable      = vec_q.e;
    assign o_MismatchCnt = cnt;
    assign o_Pass        = o_Done && (cnt == '0);

`ifdef DFFRE_BIST_FIRSTFAIL_EN
    logic [15:0] ff_step;
    logic        ff_valid;

    always_ff @(posedge clk) begin
        if (i_Reset || start_ok) begin
            ff_step  <= '0;
            ff_valid <= 1'b0;
        end else if (check_exit && mismatch && !ff_valid) begin
            ff_step  <= 16'(step);
            ff_valid <= 1'b1;
        end
    end

    assign o_FirstFailStep  = ff_step;
    assign o_FirstFailValid = ff_valid;
`else
    assign o_FirstFailStep  = '0;
    assign o_FirstFailValid = 1'b0;
`endif

endmodule

// File: doc/dffre_bist.md
# dffre_bist

Synthesizable built-in self-test engine for the `dffre_inst` flop cell, used for on-fabric sign-off. It drives a directed-then-pseudo-random stimulus sequence (D, reset, enable) into a golden/netlist pair. It then receives both Q outputs back, compares them every step, and reports a mismatch count and a pass/fail verdict.

## Interface
Parameters:
- `NUM_RANDOM`, 1000: number of random-D steps after the directed steps.
- `LFSR_SEED`, 32'hACE1_2345: nonzero LFSR reset value.
- `CNT_W`, 16: mismatch counter width.

Ports:
- `clk`  in  1  sole clock.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Start`  in  1  start pulse; honoured in IDLE or DONE only.
- `o_D`  out  1  stimulus D to both DUTs.
- `o_DutReset`  out  1  stimulus reset to both DUTs.
- `o_Enable`  out  1  stimulus enable to both DUTs.
- `i_Q_golden`  in  1  golden Q.
- `i_Q_netlist`  in  1  netlist Q.
- `o_Busy`  out  1  sequence running.
- `o_Done`  out  1  sequence complete (level, held).
- `o_Pass`  out  1  valid when `o_Done`: mismatch count == 0.
- `o_MismatchCnt`  out  CNT_W  saturating mismatch count.

## Operation
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE + `i_Start` -> APPLY. This clears the count, loads step 0 and reseeds the LFSR.
- Each step runs APPLY -> WAIT -> CHECK:
  - The vector registers update on the edge entering APPLY.
  - The DUTs capture it at the end of APPLY.
  - CHECK compares the Q inputs.
- After CHECK:
  - If steps remain: -> APPLY with the next vector.
  - Otherwise: -> DONE.
- Directed steps, as (D, R, E):
  - S0 = (1,1,0)
  - S1 = (1,0,0)
  - S2 = (1,0,1)
  - S3 = (0,0,1)
  - S4 = (1,0,1)
- Random steps R0..R(NUM_RANDOM-1): R=0, E=1, D=`lfsr[0]`. The LFSR advances once per random step, on the edge leaving CHECK.
- Mismatch is `i_Q_golden != i_Q_netlist` in CHECK. The counter increments on the CHECK exit edge and saturates at 2^CNT_W-1.
- DONE holds all status.
  - `i_Start` in DONE restarts the sequence (same as from IDLE).
  - `i_Start` in APPLY, WAIT or CHECK is ignored.
- `i_Reset` at any time: next cycle IDLE with all outputs at reset values; the run is abandoned.

## Timing
- Reset values: `o_D`=0, `o_DutReset`=1, `o_Enable`=0, `o_Busy`=0, `o_Done`=0, `o_Pass`=0, `o_MismatchCnt`=0, LFSR=`LFSR_SEED`. `o_DutReset`=1 keeps the DUTs cleared while idle.
- `i_Start` sampled at edge t: S0 on the outputs and `o_Busy`=1 from t+1.
- Step k's vector is on the outputs from t+1+3k; its compare happens in cycle t+3+3k.
- Total steps N = 5+NUM_RANDOM. `o_Done`=1 and `o_Busy`=0 from t+1+3N.
- The stimulus holds its last vector in DONE.
- The LFSR is 32-bit Galois, taps 32,22,2,1. A seed of 0 is illegal (elaboration assertion).

## Configuration
`DFFRE_BIST_FIRSTFAIL_EN`:
- Defined: adds outputs `o_FirstFailStep` [15:0] and `o_FirstFailValid`. These latch the index of the first mismatching step and stay cleared on start/reset.
- Undefined: both ports exist but are tied to 0, and no capture logic is built.

## Structure
- Package `dffre_bist_pkg`:
  - state enum
  - directed vector table (5 entries of D/R/E)
  - `NUM_DIRECTED`=5
  - LFSR tap constant
- Sub-module `bist_lfsr32`: enable plus seed-load; instantiated once.

## Test plan
Use NUM_RANDOM=4 unless stated.
- Reset then idle -> `o_DutReset`=1, `o_Busy`=0, count 0, across 10 cycles.
- `i_Start`, Q inputs tied equal -> outputs follow S0..S4 at 3-cycle spacing. After 27 cycles `o_Done`=1, `o_Pass`=1, count 0.
- `i_Q_netlist` inverted of golden throughout -> count 9, `o_Pass`=0. With the macro: first-fail step=0.
- Force a single mismatch only in step 6's CHECK -> count 1. With the macro: first-fail step=6.
- `i_Reset` asserted at step 3 -> IDLE next cycle, count 0. A new `i_Start` replays from S0 with an identical random D sequence.
- CNT_W=2, always mismatching -> count saturates at 3. `i_Start` during CHECK is ignored.
